// File: rtl/serializer_n.sv
// Multi-lane parallel-to-serial converter: CHANNELS lanes of WIDTH-bit words shifted out in lock-step,
// with a one-word holding buffer and IDLE_WORD insertion when the source runs dry.

module serializer_n_param_chk #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 3
) ();
    if ((WIDTH < 2) || (WIDTH > 16)) begin : g_bad_width
        $fatal(1, "serializer_n: WIDTH=%0d outside legal range 2..16", WIDTH);
    end
    if ((CHANNELS < 1) || (CHANNELS > 8)) begin : g_bad_channels
        $fatal(1, "serializer_n: CHANNELS=%0d outside legal range 1..8", CHANNELS);
    end
endmodule

module serializer_n #(
    parameter int               WIDTH     = 10,
    parameter int               CHANNELS  = 3,
    parameter int               MSB_FIRST = 0,
    parameter logic [WIDTH-1:0] IDLE_WORD = {WIDTH{1'b0}}
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [CHANNELS-1:0]       ser_o,
    output logic                      word_start_o,
    output logic                      underrun_o
);

    localparam int                 CW       = CHANNELS * WIDTH;
    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam int                 OUT_BIT  = (MSB_FIRST != 0) ? (WIDTH - 1) : 0;

    // What the shifters do on the coming edge
    localparam logic [1:0] LD_SHIFT  = 2'd0;
    localparam logic [1:0] LD_HOLD   = 2'd1;
    localparam logic [1:0] LD_BYPASS = 2'd2;
    localparam logic [1:0] LD_IDLE   = 2'd3;

    serializer_n_param_chk #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_param_chk ();

    logic [CNT_W-1:0]                    cnt_q,        cnt_d;
    logic                                hold_valid_q, hold_valid_d;
    logic [CW-1:0]                       hold_q,       hold_d;
    logic [CHANNELS-1:0][WIDTH-1:0]      shift_q,      shift_d;
    logic                                underrun_q,   underrun_d;
    logic                                word_start_q, word_start_d;
    logic                                ready_q,      ready_d;
    logic                                boundary_s;
    logic                                xfer_s;
    logic [1:0]                          load_sel_s;

    function automatic logic [WIDTH-1:0] lane_word(input logic [CW-1:0] bus, input int lane);
        return bus[lane*WIDTH +: WIDTH];
    endfunction

    // Moves every bit one place toward the output end; the vacated bit fills with zero
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST != 0) begin
            r = {w[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, w[WIDTH-1:1]};
        end
        return r;
    endfunction

    // Boundary decode: held word has priority, then bypass, else idle insertion
    always_comb begin
        boundary_s = (cnt_q == CNT_LAST);
        xfer_s     = valid_i && ready_q;
        if (!boundary_s) begin
            load_sel_s = LD_SHIFT;
        end else if (hold_valid_q) begin
            load_sel_s = LD_HOLD;
        end else if (xfer_s) begin
            load_sel_s = LD_BYPASS;
        end else begin
            load_sel_s = LD_IDLE;
        end
    end

    // Next-state logic for counter, hold buffer, shifters and status flags
    always_comb begin
        cnt_d        = boundary_s ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        shift_d      = shift_q;
        underrun_d   = 1'b0;

        case (load_sel_s)
            LD_SHIFT: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    shift_d[c] = shift_step(shift_q[c]);
                end
                if (xfer_s) begin
                    hold_d       = data_i;
                    hold_valid_d = 1'b1;
                end else begin
                    hold_valid_d = hold_valid_q;
                end
            end
            LD_HOLD: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    shift_d[c] = lane_word(hold_q, c);
                end
                if (xfer_s) begin
                    hold_d       = data_i;
                    hold_valid_d = 1'b1;
                end else begin
                    hold_valid_d = 1'b0;
                end
            end
            LD_BYPASS: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    shift_d[c] = lane_word(data_i, c);
                end
                hold_valid_d = 1'b0;
            end
            LD_IDLE: begin
                shift_d      = {CHANNELS{IDLE_WORD}};
                underrun_d   = 1'b1;
                hold_valid_d = 1'b0;
            end
            default: begin
                shift_d      = {CHANNELS{IDLE_WORD}};
                hold_valid_d = 1'b0;
            end
        endcase

        // Flags are precomputed from next state so the outputs come straight from flops
        word_start_d = (cnt_d == {CNT_W{1'b0}});
        ready_d      = !hold_valid_d || (cnt_d == CNT_LAST);
    end

    // State registers; reset discards any in-flight or held word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= {CNT_W{1'b0}};
            hold_valid_q <= 1'b0;
            hold_q       <= {CW{1'b0}};
            shift_q      <= {CHANNELS{IDLE_WORD}};
            underrun_q   <= 1'b0;
            word_start_q <= 1'b1;
            ready_q      <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            underrun_q   <= underrun_d;
            word_start_q <= word_start_d;
            ready_q      <= ready_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ser
        assign ser_o[c] = shift_q[c][OUT_BIT];
    end

    assign ready_o      = ready_q;
    assign word_start_o = word_start_q;
    assign underrun_o   = underrun_q;

endmodule
